// File: rtl/prog_clk_divider.sv
// Programmable clock divider: clk_out has a period of D clk cycles and a 50% duty cycle.
// Odd ratios get their extra half cycle from one negedge flop.
module prog_clk_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic             load_err,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] cur_div_reg, div_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic             pending_reg, pending_next;
    logic             run_reg, run_next;
    logic             tick_reg;
    logic             load_err_reg;
    logic             hi_pos_reg, hi_pos_next;
    logic             hi_neg_reg;

    logic at_wrap;
    logic boundary;
    logic load_ok;
    logic load_bad;

    always_comb begin
        at_wrap  = run_reg && (cnt_reg == cur_div_reg - ONE);
        // A boundary is a wrap while enabled, or a start from the stopped state.
        boundary = en && (at_wrap || !run_reg);
        load_ok  = div_load && (div_val > ONE);
        load_bad = div_load && !load_ok;

        div_next    = (boundary && pending_reg) ? shadow_reg : cur_div_reg;
        shadow_next = load_ok ? div_val : shadow_reg;

        // A load landing on a boundary stays pending for the following boundary.
        pending_next = pending_reg;
        if (load_ok)
            pending_next = 1'b1;
        else if (boundary)
            pending_next = 1'b0;

        run_next = run_reg;
        cnt_next = '0;
        if (boundary) begin
            run_next = 1'b1;
            cnt_next = '0;
        end else if (at_wrap) begin
            run_next = 1'b0;
            cnt_next = '0;
        end else if (run_reg) begin
            cnt_next = cnt_reg + ONE;
        end

        hi_pos_next = run_next && (cnt_next < (div_next >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            cur_div_reg  <= DEF_DIV;
            shadow_reg   <= '0;
            pending_reg  <= 1'b0;
            run_reg      <= 1'b0;
            tick_reg     <= 1'b0;
            load_err_reg <= 1'b0;
            hi_pos_reg   <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            cur_div_reg  <= div_next;
            shadow_reg   <= shadow_next;
            pending_reg  <= pending_next;
            run_reg      <= run_next;
            tick_reg     <= boundary;
            load_err_reg <= load_bad;
            hi_pos_reg   <= hi_pos_next;
        end
    end

    // Stretches the high phase by half a cycle for odd ratios; already low again
    // before hi_pos_reg next rises, so the OR below cannot glitch.
    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            hi_neg_reg <= 1'b0;
        else
            hi_neg_reg <= hi_pos_reg && cur_div_reg[0];
    end

    assign clk_out  = hi_pos_reg | hi_neg_reg;
    assign tick     = tick_reg;
    assign pending  = pending_reg;
    assign load_err = load_err_reg;
    assign cur_div  = cur_div_reg;

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the divide ratio and period counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 5, divide ratio loaded at reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  divider source clock; both edges are used.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  divider run enable, sampled on posedge clk.
REQ-006 SHALL have port div_val  input  WIDTH  requested divide ratio D.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe requesting div_val be adopted, sampled on posedge clk.
REQ-008 SHALL have port clk_out  output  1  divided clock, 50% duty for even and odd D.
REQ-009 SHALL have port tick  output  1  one-clk pulse marking the start of each clk_out period.
REQ-010 SHALL have port pending  output  1  high while an accepted ratio awaits its period boundary.
REQ-011 SHALL have port load_err  output  1  one-clk pulse when div_load carries an illegal div_val.
REQ-012 SHALL have port cur_div  output  WIDTH  ratio currently generating clk_out.

Function
REQ-013 SHALL keep a period counter cnt that advances 0..D-1 on posedge clk while running, wrapping to 0; the posedge where cnt becomes 0 is the period boundary.
REQ-014 SHALL assert tick for exactly one clk cycle at every period boundary, including the first after start.
REQ-015 SHALL drive clk_out high from each period boundary for D/2 clk periods when D is even, falling on a posedge.
REQ-016 SHALL drive clk_out high for D/2 clk periods (an integer plus one half) when D is odd, falling on a negedge clk.
REQ-017 SHALL produce clk_out period exactly D clk periods and high time exactly D/2 clk periods for every legal D, with no glitches or runt pulses.
REQ-018 SHALL treat div_val of 0 or 1 as illegal on div_load: ignore the request, pulse load_err the next cycle, and leave cur_div and any pending value unchanged.
REQ-019 SHALL register a legal div_load into a shadow register and raise pending the following cycle.
REQ-020 SHALL apply the shadow value to cur_div at the next period boundary and clear pending in that same cycle; the new period uses the new D.
REQ-021 SHALL let a later legal div_load overwrite an unapplied shadow value, so the last one wins.
REQ-022 SHALL apply a legal div_load that coincides with a period boundary at the following boundary, not the current one.
REQ-023 SHALL, when en is low at a period boundary, stop: cnt held at 0, clk_out held low, tick silent; en low mid-period lets the current period complete.
REQ-024 SHALL, when stopped and en is sampled high, start a new period at that posedge with tick asserted, and apply any pending value before that period.
REQ-025 SHALL keep div_load accepted and pending tracked while stopped.
REQ-026 SHALL keep cnt, tick, pending, load_err and cur_div in the posedge domain; only the odd-D falling edge may use a negedge flop.

Reset
REQ-027 SHALL, on rst high and independent of clk, force clk_out=0, tick=0, pending=0, load_err=0, cnt=0, cur_div=DEFAULT_DIV, and clear the shadow register.
REQ-028 SHALL, on rst asserted mid-period, drop clk_out to 0 immediately with no later pulse until restart.
REQ-029 SHALL treat the first posedge with rst low and en high as a period boundary.

Verification
REQ-030 Reset release, en=1, defaults -> clk_out period 5 clk, high 2.5 clk, tick every 5 cycles, cur_div=5.
REQ-031 div_load with div_val=8 mid-period -> pending high next cycle; at the next boundary cur_div=8, pending=0; clk_out then 4 high / 4 low.
REQ-032 div_load with div_val=1, then again with 0 -> load_err pulses once each, pending stays 0, cur_div unchanged, waveform unchanged.
REQ-033 Loads of 6 then 3 within one period -> only 3 is applied at the boundary; period 3, high 1.5 clk.
REQ-034 en low at cnt=2 with D=7 -> period completes, clk_out held low; en high with pending 4 -> tick, then period 4 at 50%.
REQ-035 rst pulse while clk_out high with D=9 -> clk_out low asynchronously; after release the first period is the DEFAULT_DIV period, not 9.
